// File: rtl/batch_collector.sv
// rtl/batch_collector.sv - packs per-channel pixel samples into addressed batch words
//
// Ports:
//   I_clk          single clock
//   I_rst_n        synchronous active-low reset
//   I_frame_start  one-cycle pulse on the first pixel cycle of a frame
//   I_pixel_valid  current cycle carries a pixel
//   I_pixel_data   per-channel pixel sample
//   O_data_out     completed batch word per channel, held until the next strobe
//   O_address_out  frame-relative batch index of O_data_out
//   O_batch_strobe one-cycle pulse marking a new batch on O_data_out/O_address_out
//   O_frame_done   one-cycle pulse with the strobe of the last batch in the frame
//   O_overflow     sticky flag: a pixel arrived after the frame was complete
module batch_collector #(
  parameter int CHANNEL_NUMBER    = 3,
  parameter int CHANNEL_BANDWIDTH = 128,
  parameter int PIXEL_WIDTH       = 8,
  parameter int BLOCK_DEPTH       = 480,
  localparam int PPB = CHANNEL_BANDWIDTH / PIXEL_WIDTH,
  localparam int AW  = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_frame_start,
  input  logic                         I_pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]       I_pixel_data [0:CHANNEL_NUMBER-1],
  output logic [CHANNEL_BANDWIDTH-1:0] O_data_out [0:CHANNEL_NUMBER-1],
  output logic [AW-1:0]                O_address_out,
  output logic                         O_batch_strobe,
  output logic                         O_frame_done,
  output logic                         O_overflow
);

  localparam int CW = (PPB > 1) ? $clog2(PPB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                pix_cnt;
  logic [AW-1:0]                addr_q;
  logic [CHANNEL_BANDWIDTH-1:0] sr [0:CHANNEL_NUMBER-1];

  logic [CW-1:0]                slot;
  logic [AW-1:0]                addr_base;
  logic                         accept;
  logic                         last;
  logic                         at_end;
  logic                         drop_full;
  logic [CHANNEL_BANDWIDTH-1:0] word_next [0:CHANNEL_NUMBER-1];

  // State register
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame_start wins over everything so a restart is
  // possible from any state, even on the cycle that would finish the frame.
  always_comb begin
    state_d = state_q;
    if (I_frame_start) begin
      state_d = ST_COLLECT;
    end
    if (last && at_end) begin
      state_d = ST_FULL;
    end
  end

  // Decode of the current cycle. With frame_start the slot and address are
  // forced to zero so a coincident pixel becomes pixel 0 of the new frame.
  always_comb begin
    slot      = I_frame_start ? '0 : pix_cnt;
    addr_base = I_frame_start ? '0 : addr_q;
    accept    = I_pixel_valid && (I_frame_start || (state_q == ST_COLLECT));
    last      = accept && (slot == CW'(PPB - 1));
    at_end    = (addr_base == AW'(BLOCK_DEPTH - 1));
    drop_full = I_pixel_valid && !I_frame_start && (state_q == ST_FULL);
    for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
      word_next[ch] = I_frame_start ? '0 : sr[ch];
      word_next[ch][slot*PIXEL_WIDTH +: PIXEL_WIDTH] = I_pixel_data[ch];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      pix_cnt        <= '0;
      addr_q         <= '0;
      O_address_out  <= '0;
      O_batch_strobe <= 1'b0;
      O_frame_done   <= 1'b0;
      O_overflow     <= 1'b0;
      for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
        sr[ch]         <= '0;
        O_data_out[ch] <= '0;
      end
    end else begin
      O_batch_strobe <= last;
      O_frame_done   <= last && at_end;
      if (drop_full) begin
        O_overflow <= 1'b1;
      end

      if (I_frame_start) begin
        pix_cnt <= '0;
        addr_q  <= '0;
      end

      if (accept) begin
        pix_cnt <= last ? '0 : CW'(slot + 1'b1);
        for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
          sr[ch] <= word_next[ch];
        end
      end else if (I_frame_start) begin
        for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
          sr[ch] <= '0;
        end
      end

      if (last) begin
        O_address_out <= addr_base;
        for (int ch = 0; ch < CHANNEL_NUMBER; ch++) begin
          O_data_out[ch] <= word_next[ch];
        end
        // The address parks on the last batch until the next frame_start.
        if (!at_end) begin
          addr_q <= addr_base + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/batch_collector.md
# batch_collector

Input-side packer placed directly upstream of the bank distributor. It accepts the decoded pixel stream, one PIXEL_WIDTH sample per colour channel per cycle, and shifts consecutive samples into CHANNEL_BANDWIDTH-wide batch words, one per channel. Each completed batch is presented with its frame-relative batch address and a one-cycle strobe. The distributor consumes these directly as its batch data, address and clock inputs.

## Interface
- CHANNEL_NUMBER, 3, number of colour channels / banks
- CHANNEL_BANDWIDTH, 128, bits per batch word per channel
- PIXEL_WIDTH, 8, bits per pixel sample per channel; CHANNEL_BANDWIDTH must be an integer multiple
- BLOCK_DEPTH, 480, batches per frame; the address counter spans 0..BLOCK_DEPTH-1
- Derived: PIXELS_PER_BATCH = CHANNEL_BANDWIDTH/PIXEL_WIDTH (16); AW = $clog2(BLOCK_DEPTH)

Ports:
- I_clk  in  1  single clock for all logic
- I_rst_n  in  1  reset, synchronous and active-low
- I_frame_start  in  1  one-cycle pulse marking the first pixel cycle of a frame
- I_pixel_valid  in  1  the current cycle carries a pixel
- I_pixel_data  in  [PIXEL_WIDTH-1:0] x [0:CHANNEL_NUMBER-1]  per-channel pixel sample
- O_data_out  out  [CHANNEL_BANDWIDTH-1:0] x [0:CHANNEL_NUMBER-1]  completed batch words
- O_address_out  out  AW  batch index within the frame
- O_batch_strobe  out  1  one-cycle pulse; data and address are valid while it is high
- O_frame_done  out  1  one-cycle pulse coinciding with the strobe of batch BLOCK_DEPTH-1
- O_overflow  out  1  sticky error flag; cleared only by reset

## Operation
- States:
  - IDLE (after reset): all pixels are ignored.
  - COLLECT: pixels are accumulated into batches.
  - FULL: the frame is complete; pixels are dropped.
- IDLE→COLLECT on I_frame_start.
- COLLECT→FULL when batch BLOCK_DEPTH-1 is emitted.
- FULL→COLLECT on I_frame_start.
- I_frame_start in any state: pixel counter := 0, batch address := 0, partial batch discarded, state := COLLECT.
- If I_frame_start and I_pixel_valid are both high in the same cycle, that pixel is pixel 0 of the new frame.
- In COLLECT, each valid pixel writes I_pixel_data[ch] into shift register ch at slot pix_cnt.
  - Slot k occupies bits [k*PIXEL_WIDTH +: PIXEL_WIDTH], so the first pixel lands in the LSBs.
  - pix_cnt is 0..PIXELS_PER_BATCH-1 and wraps to 0 after the last slot.
- On the valid pixel with pix_cnt == PIXELS_PER_BATCH-1:
  - The completed words, including this pixel, are registered into O_data_out.
  - The current batch address is registered into O_address_out.
  - O_batch_strobe pulses.
  - The batch address increments.
- Batch address behaviour at the end of a frame:
  - No wrap inside a frame: after batch BLOCK_DEPTH-1 the state becomes FULL.
  - The address stays at BLOCK_DEPTH-1 until the next I_frame_start.
- A valid pixel in FULL sets O_overflow. That pixel is dropped and no strobe is produced.
- Valid pixels in IDLE are dropped silently, without setting the flag.
- I_pixel_valid low: no state change. Gaps are allowed anywhere, including mid-batch.
- O_data_out and O_address_out hold their last values until the next strobe, including across I_frame_start and FULL.

## Timing
- Reset values:
  - O_data_out all 0, O_address_out 0.
  - O_batch_strobe 0, O_frame_done 0, O_overflow 0.
  - State IDLE, pix_cnt 0, internal batch address 0.
- Latency: last pixel of a batch accepted at edge N; strobe, data and address are valid in cycle N+1, visible from edge N+1.
- Strobe width is exactly 1 cycle. Back-to-back batches give a minimum strobe spacing of PIXELS_PER_BATCH cycles.
- O_frame_done is asserted in the same cycle as the strobe carrying address BLOCK_DEPTH-1.
- I_frame_start arriving in the same cycle as a pending strobe output:
  - The strobe for the completed batch still appears; outputs are already registered.
  - Counters restart on that same edge.
- Reset mid-batch: everything returns to reset values on the next edge. The partial batch is lost and no strobe is issued.
- Pure registers, no combinational path from inputs to outputs.

## Test plan
- **Basic batch:** reset, frame_start with 16 consecutive valid pixels, sample k = k+1 on ch0, 0x40+k on ch1, 0x80+k on ch2 → exactly one strobe one cycle after pixel 15; address 0; O_data_out[0] = 0x100F0E0D0C0B0A090807060504030201.
- **Gapped input:** 16 pixels with I_pixel_valid toggling every other cycle → identical data; one strobe; address 0; no strobe during gaps.
- **Full frame:** frame_start then 480×16 pixels → 480 strobes with addresses 0..479 in order; O_frame_done only with address 479; one extra pixel → O_overflow=1, no strobe; next frame_start → address restarts at 0 and O_overflow stays 1.
- **Mid-batch restart:** 7 pixels, then frame_start coinciding with a valid pixel 0xAA on all channels, then 15 more pixels → first strobe at address 0 with the LSB byte of every word = 0xAA; the 7 earlier pixels do not appear.
- **Reset mid-operation:** I_rst_n low for 1 cycle after 3 strobes and 5 pixels → all outputs zero; pixels are ignored until frame_start; no strobe without frame_start.
